// File: rtl/sindoku_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sindoku_pkg
// Description : Shared constants and types for the Sudoku board RAM arbiter.
//               The board is 9x9 cells stored one word per cell at address
//               row*9+col, so legal addresses are 0..80.
// Revision    : 1.0 - initial release
// ============================================================================
package sindoku_pkg;

    localparam int CELL_W     = 5;   // one cell value, 0 = blank
    localparam int ADDR_W     = 7;   // cell address width
    localparam int NCELLS     = 81;  // 9x9 board
    localparam int ROW_STRIDE = 9;   // cells per row

    // Which read requester is waiting for data on the next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CHK  = 2'd2
    } owner_t;

    // Linear cell address for a (row, col) pair
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] row,
                                                    input logic [3:0] col);
        return ADDR_W'(int'(row) * ROW_STRIDE + int'(col));
    endfunction

endpackage : sindoku_pkg
`default_nettype wire

// File: rtl/sindoku_rr2.sv
`default_nettype none
// ============================================================================
// Module      : sindoku_rr2
// Description : Two-requester round-robin picker. last_q records which
//               requester was served last (0 = a, 1 = b); on contention the
//               other one wins. last_q only moves on an advance strobe, i.e.
//               when the pick is actually consumed.
// Ports       : Clk, Reset (async, active-high)
//               req_a, req_b  - requests
//               advance       - pick consumed this cycle
//               grant_a/b     - one-hot pick (0 if no request)
// Revision    : 1.0 - initial release
// ============================================================================
module sindoku_rr2 (
    input  logic Clk,
    input  logic Reset,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic grant_a,
    output logic grant_b
);

    logic last_q;

    assign grant_a = req_a & (~req_b | last_q);
    assign grant_b = req_b & (~req_a | ~last_q);

    // Reset value 1 makes requester a (edit) win the first conflict
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant_b;
        end
    end

endmodule : sindoku_rr2
`default_nettype wire

// File: rtl/sindoku_board_arb.sv
`default_nettype none
// ============================================================================
// Module      : sindoku_board_arb
// Description : Shares the single-port 81-cell board RAM between the display
//               scanner (read, high priority), cursor edit (write) and the
//               solution checker (read). Edit and check alternate round-robin;
//               a pending edit/check that has been denied STARVE_LIMIT cycles
//               in a row preempts the display.
// Config      : `define SINDOKU_GIVEN_LOCK_EN to reject edits of given cells
//               (edit_locked=1): grant is still returned, the RAM is not
//               touched and edit_err pulses on the following cycle.
// Ports       : Clk, Reset (async, active-high)
//               disp_*  - display read requester (req/addr/gnt/rvalid/rdata)
//               edit_*  - edit write requester (req/addr/wdata/gnt/locked/err)
//               chk_*   - checker read requester (req/addr/gnt/rvalid/rdata)
//               mem_*   - RAM port; mem_rdata valid one cycle after a read
// Revision    : 1.0 - initial release
// ============================================================================
module sindoku_board_arb
    import sindoku_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [CELL_W-1:0] disp_rdata,
    input  logic              edit_req,
    input  logic [ADDR_W-1:0] edit_addr,
    input  logic [CELL_W-1:0] edit_wdata,
    output logic              edit_gnt,
    input  logic              chk_req,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_gnt,
    output logic              chk_rvalid,
    output logic [CELL_W-1:0] chk_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CELL_W-1:0] mem_wdata,
    input  logic [CELL_W-1:0] mem_rdata,
    output logic              edit_err,
    input  logic              edit_locked
);

    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    owner_t            owner_q, owner_d;
    logic              oor_q;          // read in flight targets a non-cell
    logic [3:0]        wait_q, wait_d;
    logic              w_low_pend, w_low_wins, w_low_gnt;
    logic              w_pick_edit, w_pick_chk;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_addr_ok, w_blocked;

    sindoku_rr2 u_rr (
        .Clk     (Clk),
        .Reset   (Reset),
        .req_a   (edit_req),
        .req_b   (chk_req),
        .advance (w_low_gnt),
        .grant_a (w_pick_edit),
        .grant_b (w_pick_chk)
    );

    // Class selection: display unless it is idle or the low class is starved
    assign w_low_pend = edit_req | chk_req;
    assign w_low_wins = w_low_pend & (~disp_req | (wait_q == C_LIMIT));

    assign disp_gnt  = ~Reset & disp_req & ~w_low_wins;
    assign edit_gnt  = ~Reset & w_low_wins & w_pick_edit;
    assign chk_gnt   = ~Reset & w_low_wins & w_pick_chk;
    assign w_low_gnt = edit_gnt | chk_gnt;

    always_comb begin
        w_sel_addr = disp_addr;
        if (edit_gnt) begin
            w_sel_addr = edit_addr;
        end else if (chk_gnt) begin
            w_sel_addr = chk_addr;
        end
    end

    assign w_addr_ok = (w_sel_addr < ADDR_W'(NCELLS));

`ifdef SINDOKU_GIVEN_LOCK_EN
    assign w_blocked = edit_gnt & edit_locked;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            edit_err <= 1'b0;
        end else begin
            edit_err <= w_blocked;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = edit_locked;
    assign w_blocked     = 1'b0;
    assign edit_err      = 1'b0;
`endif

    // Out-of-range or blocked accesses are still granted but never reach RAM
    assign mem_en    = (disp_gnt | w_low_gnt) & w_addr_ok & ~w_blocked;
    assign mem_we    = mem_en & edit_gnt;
    assign mem_addr  = w_sel_addr;
    assign mem_wdata = edit_gnt ? edit_wdata : '0;

    always_comb begin
        owner_d = OWN_NONE;
        if (disp_gnt) begin
            owner_d = OWN_DISP;
        end else if (chk_gnt) begin
            owner_d = OWN_CHK;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (w_low_gnt || !w_low_pend) begin
            wait_d = 4'd0;
        end else if (wait_q != C_LIMIT) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // Async reset clears owner_q, which discards any read still in flight
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owner_q <= OWN_NONE;
            oor_q   <= 1'b0;
            wait_q  <= 4'd0;
        end else begin
            owner_q <= owner_d;
            oor_q   <= ~w_addr_ok;
            wait_q  <= wait_d;
        end
    end

    assign disp_rvalid = (owner_q == OWN_DISP);
    assign chk_rvalid  = (owner_q == OWN_CHK);
    assign disp_rdata  = oor_q ? '0 : mem_rdata;
    assign chk_rdata   = oor_q ? '0 : mem_rdata;

endmodule : sindoku_board_arb
`default_nettype wire
